part_xfer_sched: RTL and testbench
==================================

Name: part_xfer_sched

Overview:
- Schedules transfers for a co-simulation partition between N mission-clock event sources and a single shared initiator-to-target transport channel.
- Each source posts a put (export, sut data to target) or a get (import, target data to partition).
- Grants are round-robin, one transaction at a time on the channel.
- Each source's mission clock generator is held frozen until that source's transfer completes.

Parameters:
- N_REQ, 4, number of mission-clock requesters (2..8)
- DATA_W, 9, payload width ({valid/wen, data[7:0]})
- TIMEOUT, 1023, channel watchdog limit in clk_i cycles (used only with watchdog compiled in)

Ports:
- clk_i  in  1  utility clock
- rst_ni  in  1  asynchronous active-low reset
- req_i  in  N_REQ  one-cycle request pulse per requester
- dir_i  in  N_REQ  per requester, sampled with req_i: 1=put, 0=get
- tx_data_i  in  N_REQ*DATA_W  put payload, slice i sampled with req_i[i]
- ack_o  out  N_REQ  one-cycle completion pulse
- freeze_clk_o  out  N_REQ  hold mission clock i
- rcv_data_o  out  N_REQ*DATA_W  last get result per requester
- rcv_valid_o  out  N_REQ  slice i updated this cycle (pulse, coincident with ack_o[i] on get)
- chan_req_o  out  1  channel transaction request
- chan_dir_o  out  1  direction of current transaction
- chan_id_o  out  $clog2(N_REQ)  requester/event id
- chan_wdata_o  out  DATA_W  put payload
- chan_ack_i  in  1  channel transaction complete
- chan_err_i  in  1  channel failure (valid with chan_ack_i)
- chan_rdata_i  in  DATA_W  get data, valid with chan_ack_i
- busy_o  out  1  FSM not in IDLE
- err_o  out  1  sticky fatal error
- ovf_o  out  1  sticky request-while-pending

Behaviour:
- Reset: all outputs 0; pending, buffers and rr pointer cleared; rr pointer=0; FSM=IDLE. Reset is asynchronous and abortable mid-transaction; chan_req_o drops immediately.
- Request capture: req_i[i] with pending[i]=0 sets pending[i] and latches dir_i[i] and tx_data_i slice into buffer i on that edge.
  - freeze_clk_o[i]=pending[i], registered, so it goes high the cycle after req_i.
  - req_i[i] with pending[i]=1 (not being cleared this cycle) is ignored and sets ovf_o.
  - req_i[i] in the same cycle as ack_o[i] re-arms pending[i] (set wins); freeze stays high.
- FSM states: IDLE, ISSUE, DONE, ERR.
- IDLE:
  - If any pending, grant g = first pending index at or after rr pointer, wrapping modulo N_REQ.
  - Register g and go ISSUE; chan_req_o=1 from the next cycle.
- ISSUE:
  - chan_req_o=1; chan_id_o=g; chan_dir_o and chan_wdata_o come from buffer g and are stable until ack.
  - chan_ack_i&~chan_err_i: capture chan_rdata_i into rcv slice g if get; go DONE; chan_req_o=0 next cycle.
  - chan_ack_i&chan_err_i: go ERR.
- DONE (one cycle):
  - ack_o[g]=1; rcv_valid_o[g]=1 if get; clear pending[g] (freeze drops next cycle); rr pointer=g+1 mod N_REQ; go IDLE.
- Throughput: minimum 3 cycles per transaction (IDLE, ISSUE with same-cycle ack, DONE). chan_ack_i outside ISSUE is ignored.
- ERR (terminal until reset):
  - err_o=1; chan_req_o=0; no acks; all freeze_clk_o held at current pending state.
  - New requests are still captured, so the simulation stays frozen.
- busy_o=1 in ISSUE, DONE and ERR.

Optional Feature:
- Macro PART_XFER_SCHED_WDOG_EN.
- Defined: a counter clears on entry to ISSUE and increments each ISSUE cycle without chan_ack_i. On reaching TIMEOUT it goes ERR and err_o=1 on the following cycle; ack in the same cycle as the counter reaching TIMEOUT wins.
- Undefined: no counter; ISSUE waits indefinitely and the TIMEOUT parameter is unused.

Test Plan:
- Single put: req_i[1]=1, dir=1, data=9'h1A5; channel acks 2 cycles after chan_req_o.
  - Expected: freeze_clk_o[1] high the next cycle; chan_id_o=1, chan_wdata_o=9'h1A5; ack_o[1] one cycle after chan_ack_i; freeze drops one cycle after ack.
- Get: req_i[3], dir=0; chan_rdata_i=9'h142 with ack.
  - Expected: rcv_data_o slice 3=9'h142, rcv_valid_o[3] coincident with ack_o[3].
- Round-robin: pulse req_i=4'b1111 in one cycle with immediate acks.
  - Expected: grants in order 0,1,2,3. Then re-request 0 and 2 → grants 0 then 2, rr pointer wrapping past 3.
- Overflow and re-arm:
  - Second req_i[2] while pending[2] → ovf_o=1, payload unchanged.
  - req_i[0] coincident with ack_o[0] → a second transaction for 0 follows and freeze_clk_o[0] never drops.
- Error and reset:
  - chan_ack_i with chan_err_i during ISSUE → err_o=1 and no ack_o.
  - With PART_XFER_SCHED_WDOG_EN and TIMEOUT=8, no ack → err_o high 9 cycles after chan_req_o rises.
  - rst_ni low mid-ISSUE → all outputs 0 asynchronously.

Source files
------------

// File: rtl/part_xfer_sched.sv
// Round-robin scheduler that funnels per-requester put/get transfers onto one
// shared channel and freezes each requester's mission clock while its transfer
// is outstanding. Optional channel watchdog: define PART_XFER_SCHED_WDOG_EN.
module part_xfer_sched #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned DATA_W  = 9,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [N_REQ-1:0]            req_i,
  input  logic [N_REQ-1:0]            dir_i,
  input  logic [N_REQ*DATA_W-1:0]     tx_data_i,
  output logic [N_REQ-1:0]            ack_o,
  output logic [N_REQ-1:0]            freeze_clk_o,
  output logic [N_REQ*DATA_W-1:0]     rcv_data_o,
  output logic [N_REQ-1:0]            rcv_valid_o,
  output logic                        chan_req_o,
  output logic                        chan_dir_o,
  output logic [$clog2(N_REQ)-1:0]    chan_id_o,
  output logic [DATA_W-1:0]           chan_wdata_o,
  input  logic                        chan_ack_i,
  input  logic                        chan_err_i,
  input  logic [DATA_W-1:0]           chan_rdata_i,
  output logic                        busy_o,
  output logic                        err_o,
  output logic                        ovf_o
);

  localparam int unsigned ID_W = $clog2(N_REQ);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam logic [1:0] S_ERR   = 2'd3;

  generate
    if (N_REQ < 2 || N_REQ > 8 || TIMEOUT < 1) begin : g_param_check
      $error("part_xfer_sched: unsupported parameter set");
    end
  endgenerate

  logic [1:0]        state, state_nxt;
  logic [N_REQ-1:0]  pending;
  logic [N_REQ-1:0]  dir_buf;
  logic [DATA_W-1:0] data_buf [N_REQ];
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   gnt;
  logic [ID_W-1:0]   cand;
  logic [ID_W-1:0]   pick;
  logic              pick_vld;
  logic [N_REQ-1:0]  gnt_oh;
  logic [N_REQ-1:0]  clr_vec;
  logic [N_REQ-1:0]  cap_vec;
  logic              issue_ok;
  logic              wdog_expired;

  assign freeze_clk_o = pending;

  // First pending requester at or after the round-robin pointer, wrapping.
  always_comb begin
    pick_vld = 1'b0;
    pick     = '0;
    cand     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = ID_W'((32'(rr_ptr) + 32'(k)) % N_REQ);
      if (!pick_vld && pending[cand]) begin
        pick_vld = 1'b1;
        pick     = cand;
      end
    end
  end

  always_comb begin
    gnt_oh      = '0;
    gnt_oh[gnt] = 1'b1;
  end

  // A completing requester may re-arm in its own DONE cycle.
  assign clr_vec  = (state == S_DONE) ? gnt_oh : '0;
  assign cap_vec  = req_i & (~pending | clr_vec);
  assign issue_ok = (state == S_ISSUE) && chan_ack_i && !chan_err_i;

`ifdef PART_XFER_SCHED_WDOG_EN
  localparam int unsigned WDOG_W = $clog2(TIMEOUT + 1);

  logic [WDOG_W-1:0] wdog_cnt;

  // Saturating count of ISSUE cycles spent waiting for the channel.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wdog_cnt <= '0;
    end else if (state != S_ISSUE) begin
      wdog_cnt <= '0;
    end else if (!chan_ack_i && (wdog_cnt != WDOG_W'(TIMEOUT))) begin
      wdog_cnt <= wdog_cnt + 1'b1;
    end
  end

  assign wdog_expired = (wdog_cnt == WDOG_W'(TIMEOUT));
`else
  assign wdog_expired = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ERR is terminal; a completing ack outranks the watchdog.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (pick_vld) state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        if (chan_ack_i) begin
          state_nxt = chan_err_i ? S_ERR : S_DONE;
        end else if (wdog_expired) begin
          state_nxt = S_ERR;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_ERR;
      end
    endcase
  end

  // Status and channel outputs, registered from the next state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      chan_req_o   <= 1'b0;
      busy_o       <= 1'b0;
      err_o        <= 1'b0;
      ack_o        <= '0;
      rcv_valid_o  <= '0;
      gnt          <= '0;
      chan_id_o    <= '0;
      chan_dir_o   <= 1'b0;
      chan_wdata_o <= '0;
      rr_ptr       <= '0;
    end else begin
      chan_req_o  <= (state_nxt == S_ISSUE);
      busy_o      <= (state_nxt != S_IDLE);
      err_o       <= (state_nxt == S_ERR);
      ack_o       <= issue_ok ? gnt_oh : '0;
      rcv_valid_o <= (issue_ok && !dir_buf[gnt]) ? gnt_oh : '0;
      if ((state == S_IDLE) && pick_vld) begin
        gnt          <= pick;
        chan_id_o    <= pick;
        chan_dir_o   <= dir_buf[pick];
        chan_wdata_o <= data_buf[pick];
      end
      if (state == S_DONE) begin
        rr_ptr <= (gnt == ID_W'(N_REQ - 1)) ? '0 : gnt + 1'b1;
      end
    end
  end

  // Request capture into per-requester buffers; capture continues in ERR.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending <= '0;
      dir_buf <= '0;
      ovf_o   <= 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
        data_buf[i] <= '0;
      end
    end else begin
      pending <= (pending & ~clr_vec) | cap_vec;
      ovf_o   <= ovf_o | (|(req_i & pending & ~clr_vec));
      for (int i = 0; i < N_REQ; i++) begin
        if (cap_vec[i]) begin
          dir_buf[i]  <= dir_i[i];
          data_buf[i] <= tx_data_i[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Get results land in the granted requester's slice on the completing ack.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rcv_data_o <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (issue_ok && gnt_oh[i] && !dir_buf[i]) begin
          rcv_data_o[i*DATA_W +: DATA_W] <= chan_rdata_i;
        end
      end
    end
  end

endmodule

// File: tb/tb_part_xfer_sched.sv
// Directed bench for part_xfer_sched: cycle vector table plus hand sequences
// for channel error, asynchronous reset and (when compiled in) the watchdog.
module tb_part_xfer_sched;

  localparam int NV = 42;

  logic        clk;
  logic        rst_ni;
  logic [3:0]  req_i;
  logic [3:0]  dir_i;
  logic [35:0] tx_data_i;
  logic [3:0]  ack_o;
  logic [3:0]  freeze_clk_o;
  logic [35:0] rcv_data_o;
  logic [3:0]  rcv_valid_o;
  logic        chan_req_o;
  logic        chan_dir_o;
  logic [1:0]  chan_id_o;
  logic [8:0]  chan_wdata_o;
  logic        chan_ack_i;
  logic        chan_err_i;
  logic [8:0]  chan_rdata_i;
  logic        busy_o;
  logic        err_o;
  logic        ovf_o;

  int checks = 0;
  int errors = 0;

  part_xfer_sched #(.N_REQ(4), .DATA_W(9), .TIMEOUT(8)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .req_i        (req_i),
    .dir_i        (dir_i),
    .tx_data_i    (tx_data_i),
    .ack_o        (ack_o),
    .freeze_clk_o (freeze_clk_o),
    .rcv_data_o   (rcv_data_o),
    .rcv_valid_o  (rcv_valid_o),
    .chan_req_o   (chan_req_o),
    .chan_dir_o   (chan_dir_o),
    .chan_id_o    (chan_id_o),
    .chan_wdata_o (chan_wdata_o),
    .chan_ack_i   (chan_ack_i),
    .chan_err_i   (chan_err_i),
    .chan_rdata_i (chan_rdata_i),
    .busy_o       (busy_o),
    .err_o        (err_o),
    .ovf_o        (ovf_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  dir;
    logic [35:0] txd;
    logic        cack;
    logic [8:0]  rd;
    logic [3:0]  fr;
    logic [3:0]  ack;
    logic [3:0]  rv;
    logic        creq;
    logic [1:0]  cid;
    logic [8:0]  wd;
    logic        busy;
    logic        ovf;
    logic [35:0] rcv;
  } vec_t;

  vec_t vecs [NV];

  function automatic vec_t mk(input logic [3:0] req, input logic [3:0] dir,
                              input logic [35:0] txd, input logic cack, input logic [8:0] rd,
                              input logic [3:0] fr, input logic [3:0] ack, input logic [3:0] rv,
                              input logic creq, input logic [1:0] cid, input logic [8:0] wd,
                              input logic busy, input logic ovf, input logic [35:0] rcv);
    vec_t v;
    v.req = req; v.dir = dir; v.txd = txd; v.cack = cack; v.rd = rd;
    v.fr = fr; v.ack = ack; v.rv = rv; v.creq = creq; v.cid = cid;
    v.wd = wd; v.busy = busy; v.ovf = ovf; v.rcv = rcv;
    return v;
  endfunction

  function automatic logic [35:0] d4(input logic [8:0] s3, input logic [8:0] s2,
                                     input logic [8:0] s1, input logic [8:0] s0);
    return {s3, s2, s1, s0};
  endfunction

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    req_i = 4'b0; dir_i = 4'b0; tx_data_i = 36'd0;
    chan_ack_i = 1'b0; chan_err_i = 1'b0; chan_rdata_i = 9'd0;
  endtask

  function automatic logic [127:0] all_outs();
    return 128'({freeze_clk_o, ack_o, rcv_valid_o, chan_req_o, chan_dir_o, chan_id_o,
                 chan_wdata_o, busy_o, err_o, ovf_o, rcv_data_o});
  endfunction

  localparam logic [35:0] Z36 = 36'd0;
  localparam logic [35:0] R3  = {9'h142, 27'd0};

  initial begin
    int n;
    idle_inputs();
    rst_ni = 1'b0;

    //                req      dir      txd                                 ack   rd       fr       ack      rv       creq  cid   wd      busy  ovf   rcv
    vecs[0]  = mk(4'b0010, 4'b0010, d4(9'h0, 9'h0, 9'h1A5, 9'h0),       1'b0, 9'h0,   4'b0010, 4'b0000, 4'b0000, 1'b0, 2'd0, 9'h000, 1'b0, 1'b0, Z36);
    vecs[1]  = mk(4'b0000, 4'b0000, Z36,                                1'b0, 9'h0,   4'b0010, 4'b0000, 4'b0000, 1'b1, 2'd1, 9'h1A5, 1'b1, 1'b0, Z36);
    vecs[2]  = mk(4'b0000, 4'b0000, Z36,                                1'b0, 9'h0,   4'b0010, 4'b0000, 4'b0000, 1'b1, 2'd1, 9'h1A5, 1'b1, 1'b0, Z36);
    vecs[3]  = mk(4'b0000, 4'b0000, Z36,                                1'b1, 9'h0,   4'b0010, 4'b0010, 4'b0000, 1'b0, 2'd1, 9'h1A5, 1'b1, 1'b0, Z36);
    vecs[4]  = mk(4'b0000, 4'b0000, Z36,                                1'b0, 9'h0,   4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd1, 9'h1A5, 1'b0, 1'b0, Z36);
    vecs[5]  = mk(4'b1000, 4'b0000, Z36,                                1'b0, 9'h0,   4'b1000, 4'b0000, 4'b0000, 1'b0, 2'd1, 9'h1A5, 1'b0, 1'b0, Z36);
    vecs[6]  = mk(4'b0000, 4'b0000, Z36,                                1'b0, 9'h0,   4'b1000, 4'b0000, 4'b0000, 1'b1, 2'd3, 9'h000, 1'b1, 1'b0, Z36);
    vecs[7]  = mk(4'b0000, 4'b0000, Z36,                                1'b1, 9'h142, 4'b1000, 4'b1000, 4'b1000, 1'b0, 2'd3, 9'h000, 1'b1, 1'b0, R3);
    vecs[8]  = mk(4'b0000, 4'b0000, Z36,                                1'b0, 9'h0,   4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd3, 9'h000, 1'b0, 1'b0, R3);
    vecs[9]  = mk(4'b1111, 4'b1111, d4(9'h13, 9'h12, 9'h11, 9'h10),     1'b1, 9'h0,   4'b1111, 4'b0000, 4'b0000, 1'b0, 2'd3, 9'h000, 1'b0, 1'b0, R3);
    vecs[10] = mk(4'b0000, 4'b0000, Z36,                                1'b1, 9'h0,   4'b1111, 4'b0000, 4'b0000, 1'b1, 2'd0, 9'h010, 1'b1, 1'b0, R3);
    vecs[11] = mk(4'b0000, 4'b0000, Z36,                                1'b1, 9'h0,   4'b1111, 4'b0001, 4'b0000, 1'b0, 2'd0, 9'h010, 1'b1, 1'b0, R3);
    vecs[12] = mk(4'b0000, 4'b0000, Z36,                                1'b1, 9'h0,   4'b1110, 4'b0000, 4'b0000, 1'b0, 2'd0, 9'h010, 1'b0, 1'b0, R3);
    vecs[13] = mk(4'b0000, 4'b0000, Z36,                                1'b1, 9'h0,   4'b1110, 4'b0000, 4'b0000, 1'b1, 2'd1, 9'h011, 1'b1, 1'b0, R3);
    vecs[14] = mk(4'b0000, 4'b0000, Z36,                                1'b1, 9'h0,   4'b1110, 4'b0010, 4'b0000, 1'b0, 2'd1, 9'h011, 1'b1, 1'b0, R3);
    vecs[15] = mk(4'b0000, 4'b0000, Z36,                                1'b1, 9'h0,   4'b1100, 4'b0000, 4'b0000, 1'b0, 2'd1, 9'h011, 1'b0, 1'b0, R3);
    vecs[16] = mk(4'b0000, 4'b0000, Z36,                                1'b1, 9'h0,   4'b1100, 4'b0000, 4'b0000, 1'b1, 2'd2, 9'h012, 1'b1, 1'b0, R3);
    vecs[17] = mk(4'b0000, 4'b0000, Z36,                                1'b1, 9'h0,   4'b1100, 4'b0100, 4'b0000, 1'b0, 2'd2, 9'h012, 1'b1, 1'b0, R3);
    vecs[18] = mk(4'b0000, 4'b0000, Z36,                                1'b1, 9'h0,   4'b1000, 4'b0000, 4'b0000, 1'b0, 2'd2, 9'h012, 1'b0, 1'b0, R3);
    vecs[19] = mk(4'b0000, 4'b0000, Z36,                                1'b1, 9'h0,   4'b1000, 4'b0000, 4'b0000, 1'b1, 2'd3, 9'h013, 1'b1, 1'b0, R3);
    vecs[20] = mk(4'b0000, 4'b0000, Z36,                                1'b1, 9'h0,   4'b1000, 4'b1000, 4'b0000, 1'b0, 2'd3, 9'h013, 1'b1, 1'b0, R3);
    vecs[21] = mk(4'b0101, 4'b0101, d4(9'h0, 9'h22, 9'h0, 9'h20),       1'b1, 9'h0,   4'b0101, 4'b0000, 4'b0000, 1'b0, 2'd3, 9'h013, 1'b0, 1'b0, R3);
    vecs[22] = mk(4'b0000, 4'b0000, Z36,                                1'b1, 9'h0,   4'b0101, 4'b0000, 4'b0000, 1'b1, 2'd0, 9'h020, 1'b1, 1'b0, R3);
    vecs[23] = mk(4'b0000, 4'b0000, Z36,                                1'b1, 9'h0,   4'b0101, 4'b0001, 4'b0000, 1'b0, 2'd0, 9'h020, 1'b1, 1'b0, R3);
    vecs[24] = mk(4'b0000, 4'b0000, Z36,                                1'b1, 9'h0,   4'b0100, 4'b0000, 4'b0000, 1'b0, 2'd0, 9'h020, 1'b0, 1'b0, R3);
    vecs[25] = mk(4'b0000, 4'b0000, Z36,                                1'b1, 9'h0,   4'b0100, 4'b0000, 4'b0000, 1'b1, 2'd2, 9'h022, 1'b1, 1'b0, R3);
    vecs[26] = mk(4'b0000, 4'b0000, Z36,                                1'b1, 9'h0,   4'b0100, 4'b0100, 4'b0000, 1'b0, 2'd2, 9'h022, 1'b1, 1'b0, R3);
    vecs[27] = mk(4'b0000, 4'b0000, Z36,                                1'b0, 9'h0,   4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd2, 9'h022, 1'b0, 1'b0, R3);
    vecs[28] = mk(4'b0110, 4'b0110, d4(9'h0, 9'h55, 9'h31, 9'h0),       1'b0, 9'h0,   4'b0110, 4'b0000, 4'b0000, 1'b0, 2'd2, 9'h022, 1'b0, 1'b0, R3);
    vecs[29] = mk(4'b0100, 4'b0100, d4(9'h0, 9'h1FF, 9'h0, 9'h0),       1'b0, 9'h0,   4'b0110, 4'b0000, 4'b0000, 1'b1, 2'd1, 9'h031, 1'b1, 1'b1, R3);
    vecs[30] = mk(4'b0000, 4'b0000, Z36,                                1'b1, 9'h0,   4'b0110, 4'b0010, 4'b0000, 1'b0, 2'd1, 9'h031, 1'b1, 1'b1, R3);
    vecs[31] = mk(4'b0000, 4'b0000, Z36,                                1'b0, 9'h0,   4'b0100, 4'b0000, 4'b0000, 1'b0, 2'd1, 9'h031, 1'b0, 1'b1, R3);
    vecs[32] = mk(4'b0000, 4'b0000, Z36,                                1'b0, 9'h0,   4'b0100, 4'b0000, 4'b0000, 1'b1, 2'd2, 9'h055, 1'b1, 1'b1, R3);
    vecs[33] = mk(4'b0000, 4'b0000, Z36,                                1'b1, 9'h0,   4'b0100, 4'b0100, 4'b0000, 1'b0, 2'd2, 9'h055, 1'b1, 1'b1, R3);
    vecs[34] = mk(4'b0000, 4'b0000, Z36,                                1'b0, 9'h0,   4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd2, 9'h055, 1'b0, 1'b1, R3);
    vecs[35] = mk(4'b0001, 4'b0001, d4(9'h0, 9'h0, 9'h0, 9'h0A),        1'b0, 9'h0,   4'b0001, 4'b0000, 4'b0000, 1'b0, 2'd2, 9'h055, 1'b0, 1'b1, R3);
    vecs[36] = mk(4'b0000, 4'b0000, Z36,                                1'b0, 9'h0,   4'b0001, 4'b0000, 4'b0000, 1'b1, 2'd0, 9'h00A, 1'b1, 1'b1, R3);
    vecs[37] = mk(4'b0000, 4'b0000, Z36,                                1'b1, 9'h0,   4'b0001, 4'b0001, 4'b0000, 1'b0, 2'd0, 9'h00A, 1'b1, 1'b1, R3);
    vecs[38] = mk(4'b0001, 4'b0001, d4(9'h0, 9'h0, 9'h0, 9'h0B),        1'b0, 9'h0,   4'b0001, 4'b0000, 4'b0000, 1'b0, 2'd0, 9'h00A, 1'b0, 1'b1, R3);
    vecs[39] = mk(4'b0000, 4'b0000, Z36,                                1'b0, 9'h0,   4'b0001, 4'b0000, 4'b0000, 1'b1, 2'd0, 9'h00B, 1'b1, 1'b1, R3);
    vecs[40] = mk(4'b0000, 4'b0000, Z36,                                1'b1, 9'h0,   4'b0001, 4'b0001, 4'b0000, 1'b0, 2'd0, 9'h00B, 1'b1, 1'b1, R3);
    vecs[41] = mk(4'b0000, 4'b0000, Z36,                                1'b0, 9'h0,   4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, 9'h00B, 1'b0, 1'b1, R3);

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_state", all_outs(), 128'd0);
    rst_ni = 1'b1;

    // Cycle table: drive at negedge, compare at the following negedge.
    for (int k = 0; k < NV; k++) begin
      req_i        = vecs[k].req;
      dir_i        = vecs[k].dir;
      tx_data_i    = vecs[k].txd;
      chan_ack_i   = vecs[k].cack;
      chan_err_i   = 1'b0;
      chan_rdata_i = vecs[k].rd;
      tick();
      check($sformatf("vec%0d", k),
            128'({freeze_clk_o, ack_o, rcv_valid_o, chan_req_o, chan_id_o, chan_wdata_o,
                  busy_o, err_o, ovf_o, rcv_data_o}),
            128'({vecs[k].fr, vecs[k].ack, vecs[k].rv, vecs[k].creq, vecs[k].cid, vecs[k].wd,
                  vecs[k].busy, 1'b0, vecs[k].ovf, vecs[k].rcv}));
    end
    idle_inputs();

    // Channel error during a get: terminal ERR, no ack, requests still frozen.
    req_i = 4'b0010; dir_i = 4'b0000;
    tick();
    idle_inputs();
    tick();
    check("err_issue", 128'({chan_req_o, chan_dir_o, chan_id_o}), 128'({1'b1, 1'b0, 2'd1}));
    chan_ack_i = 1'b1; chan_err_i = 1'b1; chan_rdata_i = 9'h077;
    tick();
    idle_inputs();
    check("err_entry", 128'({err_o, busy_o, chan_req_o, ack_o, rcv_valid_o, rcv_data_o}),
          128'({1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000, R3}));
    req_i = 4'b0001; dir_i = 4'b0001;
    tick();
    idle_inputs();
    check("err_capture", 128'(freeze_clk_o), 128'(4'b0011));
    chan_ack_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("err_hold%0d", k), 128'({err_o, chan_req_o, ack_o, freeze_clk_o}),
            128'({1'b1, 1'b0, 4'b0000, 4'b0011}));
    end
    idle_inputs();

    // Reset out of ERR, then abort a live transaction asynchronously.
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    check("reset_from_err", all_outs(), 128'd0);
    req_i = 4'b0100; dir_i = 4'b0100; tx_data_i = d4(9'h0, 9'h099, 9'h0, 9'h0);
    tick();
    idle_inputs();
    tick();
    check("pre_abort", 128'({chan_req_o, chan_id_o, chan_wdata_o}), 128'({1'b1, 2'd2, 9'h099}));
    #2 rst_ni = 1'b0;
    #1 check("async_abort", all_outs(), 128'd0);
    @(negedge clk);
    rst_ni = 1'b1;

`ifdef PART_XFER_SCHED_WDOG_EN
    req_i = 4'b0001; dir_i = 4'b0001;
    tick();
    idle_inputs();
    tick();
    check("wdog_issue", 128'(chan_req_o), 128'(1'b1));
    n = 0;
    while (!err_o && n < 20) begin
      tick();
      n++;
    end
    check("wdog_latency", 128'(n), 128'(9));
    check("wdog_no_ack", 128'({ack_o, chan_req_o}), 128'({4'b0000, 1'b0}));
`else
    n = 0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
